// File: rtl/instr_mem_loadable.sv
// Synchronous instruction memory with a registered fetch port and a valid/ready program-load port.
// Addresses at or beyond the loaded program length read back as FILL_WORD.
module instr_mem_loadable #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(16'h6000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_err,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_trunc,
    output logic [ADDR_W:0]   prog_len
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LAST_L  = LEN_W'(DEPTH - 1);

    typedef enum logic {RUN, LOAD} state_e;

    state_e            state_q, state_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_instr_q, fetch_instr_d;
    logic              fetch_err_q, fetch_err_d;
    logic              load_done_q, load_done_d;
    logic              load_trunc_q, load_trunc_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic              mem_we;
    logic [LEN_W-1:0]  addr_ext;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign addr_ext = {1'b0, fetch_addr};

    // Next-state, fetch datapath and load handshake
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = 1'b0;
        fetch_instr_d = fetch_instr_q;
        fetch_err_d   = fetch_err_q;
        load_done_d   = 1'b0;
        load_trunc_d  = load_trunc_q;
        prog_len_d    = prog_len_q;
        ptr_d         = ptr_q;
        mem_we        = 1'b0;
        case (state_q)
            RUN: begin
                if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    if (addr_ext >= DEPTH_L) begin
                        fetch_instr_d = FILL_WORD;
                        fetch_err_d   = 1'b1;
                    end else if (addr_ext >= prog_len_q) begin
                        fetch_instr_d = FILL_WORD;
                        fetch_err_d   = 1'b0;
                    end else begin
                        fetch_instr_d = mem_q[fetch_addr[IDX_W-1:0]];
                        fetch_err_d   = 1'b0;
                    end
                end
                if (load_start) begin
                    state_d      = LOAD;
                    ptr_d        = '0;
                    prog_len_d   = '0;
                    load_trunc_d = 1'b0;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + LEN_W'(1);
                    // A final beat or a full array both end the load
                    if (load_last || (ptr_q == LAST_L)) begin
                        prog_len_d  = ptr_q + LEN_W'(1);
                        state_d     = RUN;
                        load_done_d = 1'b1;
                        if (!load_last) begin
                            load_trunc_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= FILL_WORD;
            fetch_err_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_trunc_q  <= 1'b0;
            prog_len_q    <= '0;
            ptr_q         <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_err_q   <= fetch_err_d;
            load_done_q   <= load_done_d;
            load_trunc_q  <= load_trunc_d;
            prog_len_q    <= prog_len_d;
            ptr_q         <= ptr_d;
        end
    end

    // Array is not reset; prog_len masks stale contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_err   = fetch_err_q;
    assign busy        = (state_q == LOAD);
    assign load_ready  = (state_q == LOAD);
    assign load_done   = load_done_q;
    assign load_trunc  = load_trunc_q;
    assign prog_len    = prog_len_q;

endmodule
